// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key schedule and the round datapath.
package aes_pkg;

    typedef logic [31:0] word_t;

    // Index 0 is the first word of the key/state. Its byte [31:24] is the first byte.
    typedef word_t [3:0] state_t;

    localparam int NR = 10;

    // Only entries 1..10 are meaningful. The padding lets a 4-bit round index
    // address the table without a range guard.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } ke_state_e;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: combinational byte substitution, shared by SubWord and SubBytes.
module aes_sbox (
    input  logic [7:0] plain,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup.
    always_comb begin
        subst = SBOX[plain];
    end

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule. It produces round keys 0..NR one at a time behind a
// valid/ready handshake. Each next key is derived combinationally from the
// key register, so the key register is the only storage for rk_o.
//
// state  | meaning
// IDLE   | ready for start_i; rk_valid_o low
// EXPAND | rk_o holds key round_o; advances on each handshake
module key_expand
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  state_t     key_i,
    input  logic       start_i,
    output logic       ready_o,
    output state_t     rk_o,
    output logic       rk_valid_o,
    input  logic       rk_ready_i,
    output logic [3:0] round_o,
    output logic       done_o
);

    localparam logic [3:0] LAST = NR[3:0];

    ke_state_e  state_q;
    ke_state_e  state_d;
    state_t     key_q;
    state_t     key_next;
    logic [3:0] round_q;
    logic [3:0] round_inc;
    word_t      rot_word;
    word_t      sub_word;
    word_t      temp;
    logic       accept;
    logic       handshake;
    logic       last_key;

    assign round_inc = round_q + 4'd1;
    assign rot_word  = {key_q[3][23:0], key_q[3][31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .plain (rot_word[8*i +: 8]),
            .subst (sub_word[8*i +: 8])
        );
    end

    // Next round key from the current one. Rcon is taken for round r+1.
    always_comb begin
        temp        = sub_word ^ {RCON[round_inc], 24'h000000};
        key_next    = key_q;
        key_next[0] = key_q[0] ^ temp;
        key_next[1] = key_q[1] ^ key_next[0];
        key_next[2] = key_q[2] ^ key_next[1];
        key_next[3] = key_q[3] ^ key_next[2];
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        ready_o    = 1'b0;
        rk_valid_o = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        last_key   = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                accept  = start_i;
                if (start_i) begin
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                rk_valid_o = 1'b1;
                handshake  = rk_ready_i;
                last_key   = (round_q == LAST);
                if (rk_ready_i && last_key) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Key register and round index: load on start, advance on a non-final handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q   <= '0;
            round_q <= 4'd0;
        end else if (accept) begin
            key_q   <= key_i;
            round_q <= 4'd0;
        end else if (handshake && !last_key) begin
            key_q   <= key_next;
            round_q <= round_inc;
        end
    end

    assign rk_o    = key_q;
    assign round_o = round_q;

endmodule

// File: tb/tb_key_expand.sv
// Directed bench for key_expand using FIPS-197 and all-zero key vectors.
module tb_key_expand;
    import aes_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    state_t     key_i;
    logic       start_i;
    logic       ready_o;
    state_t     rk_o;
    logic       rk_valid_o;
    logic       rk_ready_i;
    logic [3:0] round_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rdy;
        logic       strt;
        logic [3:0] exp_round;
        logic       exp_done;
    } stall_vec_t;

    logic [127:0] fips_rk [0:10];
    stall_vec_t   stall_tab [0:19];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] PT       = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ARK0     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    key_expand #(.NR(10)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .key_i      (key_i),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .rk_o       (rk_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .round_o    (round_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] flat(input state_t s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    function automatic state_t unflat(input logic [127:0] k);
        state_t s;
        s[0] = k[127:96];
        s[1] = k[95:64];
        s[2] = k[63:32];
        s[3] = k[31:0];
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer a key with start_i for one cycle. Returns at the negedge where round 0 is expected.
    task automatic do_start(input logic [127:0] k);
        @(negedge clk_i);
        key_i      = unflat(k);
        start_i    = 1'b1;
        rk_ready_i = 1'b0;
        #1;
        chk("ready_before_start", ready_o, 1);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        stall_tab[0]  = '{1'b1, 1'b0, 4'd0,  1'b0};
        stall_tab[1]  = '{1'b0, 1'b0, 4'd1,  1'b0};
        stall_tab[2]  = '{1'b0, 1'b1, 4'd1,  1'b0};
        stall_tab[3]  = '{1'b1, 1'b0, 4'd1,  1'b0};
        stall_tab[4]  = '{1'b1, 1'b1, 4'd2,  1'b0};
        stall_tab[5]  = '{1'b0, 1'b0, 4'd3,  1'b0};
        stall_tab[6]  = '{1'b1, 1'b0, 4'd3,  1'b0};
        stall_tab[7]  = '{1'b0, 1'b0, 4'd4,  1'b0};
        stall_tab[8]  = '{1'b1, 1'b0, 4'd4,  1'b0};
        stall_tab[9]  = '{1'b1, 1'b0, 4'd5,  1'b0};
        stall_tab[10] = '{1'b0, 1'b0, 4'd6,  1'b0};
        stall_tab[11] = '{1'b0, 1'b1, 4'd6,  1'b0};
        stall_tab[12] = '{1'b0, 1'b0, 4'd6,  1'b0};
        stall_tab[13] = '{1'b1, 1'b0, 4'd6,  1'b0};
        stall_tab[14] = '{1'b1, 1'b0, 4'd7,  1'b0};
        stall_tab[15] = '{1'b0, 1'b0, 4'd8,  1'b0};
        stall_tab[16] = '{1'b1, 1'b0, 4'd8,  1'b0};
        stall_tab[17] = '{1'b1, 1'b0, 4'd9,  1'b0};
        stall_tab[18] = '{1'b0, 1'b1, 4'd10, 1'b0};
        stall_tab[19] = '{1'b1, 1'b0, 4'd10, 1'b1};

        rst_i      = 1'b1;
        start_i    = 1'b0;
        rk_ready_i = 1'b0;
        key_i      = unflat(128'h0);

        // Reset state
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", rk_valid_o, 0);
        chk("rst_rk", flat(rk_o), 128'h0);
        chk("rst_round", round_o, 0);
        chk("rst_done", done_o, 0);

        // FIPS-197 key, no stalls; start offered on the final handshake
        do_start(FIPS_KEY);
        for (int i = 0; i <= 10; i++) begin
            rk_ready_i = 1'b1;
            start_i    = (i == 10);
            if (i == 10) key_i = unflat(ALT_KEY);
            #1;
            chk("fips_valid", rk_valid_o, 1);
            chk("fips_round", round_o, i);
            chk($sformatf("fips_rk%0d", i), flat(rk_o), fips_rk[i]);
            chk("fips_done", done_o, (i == 10));
            chk("fips_ready", ready_o, 0);
            if (i == 0) chk("ark_round0", flat(rk_o) ^ PT, ARK0);
            @(negedge clk_i);
        end
        start_i    = 1'b0;
        rk_ready_i = 1'b0;
        #1;
        chk("fips_end_ready", ready_o, 1);
        chk("fips_end_valid", rk_valid_o, 0);
        chk("fips_end_done", done_o, 0);
        @(negedge clk_i);
        #1;
        chk("start_on_last_ignored", rk_valid_o, 0);

        // All-zero key
        do_start(128'h0);
        for (int i = 0; i <= 10; i++) begin
            rk_ready_i = 1'b1;
            #1;
            chk("zero_round", round_o, i);
            if (i == 0) chk("zero_rk0", flat(rk_o), 128'h0);
            if (i == 1) chk("zero_rk1", flat(rk_o), 128'h62636363626363636263636362636363);
            if (i == 2) chk("zero_rk2", flat(rk_o), 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
            chk("zero_done", done_o, (i == 10));
            @(negedge clk_i);
        end
        rk_ready_i = 1'b0;
        #1;
        chk("zero_end_ready", ready_o, 1);

        // Stalls, with start_i pulses and a changed key_i during the expansion
        do_start(FIPS_KEY);
        for (int k = 0; k < 20; k++) begin
            rk_ready_i = stall_tab[k].rdy;
            start_i    = stall_tab[k].strt;
            if (k >= 1) key_i = unflat(ALT_KEY);
            #1;
            chk("stall_valid", rk_valid_o, 1);
            chk($sformatf("stall_round_%0d", k), round_o, stall_tab[k].exp_round);
            chk($sformatf("stall_rk_%0d", k), flat(rk_o), fips_rk[stall_tab[k].exp_round]);
            chk($sformatf("stall_done_%0d", k), done_o, stall_tab[k].exp_done);
            @(negedge clk_i);
        end
        start_i    = 1'b0;
        rk_ready_i = 1'b0;
        #1;
        chk("stall_end_ready", ready_o, 1);
        chk("stall_end_valid", rk_valid_o, 0);

        // Reset at round 5 aborts the expansion
        do_start(FIPS_KEY);
        for (int i = 0; i < 5; i++) begin
            rk_ready_i = 1'b1;
            @(negedge clk_i);
        end
        rk_ready_i = 1'b0;
        rst_i      = 1'b1;
        #1;
        chk("abort_at_round", round_o, 5);
        chk("abort_rk5", flat(rk_o), fips_rk[5]);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("abort_valid", rk_valid_o, 0);
        chk("abort_rk", flat(rk_o), 128'h0);
        chk("abort_round", round_o, 0);
        chk("abort_ready", ready_o, 1);
        chk("abort_done", done_o, 0);
        rk_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("abort_no_resume", rk_valid_o, 0);
        chk("abort_no_done", done_o, 0);
        do_start(FIPS_KEY);
        rk_ready_i = 1'b0;
        #1;
        chk("restart_valid", rk_valid_o, 1);
        chk("restart_round", round_o, 0);
        chk("restart_rk0", flat(rk_o), fips_rk[0]);
        rk_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("restart_rk1", flat(rk_o), fips_rk[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
